// File: rtl/video_pkg.sv
// Shared types and defaults for the video fetch arbiter and its fetch tracker.
package video_pkg;

    typedef enum logic [1:0] {
        S_SH       = 2'd0,
        S_DRAIN_VK = 2'd1,
        S_VK       = 2'd2,
        S_DRAIN_SH = 2'd3
    } arb_state_e;

    localparam logic OWN_SH = 1'b0;
    localparam logic OWN_VK = 1'b1;

    localparam logic [1:0]  SLOT_DEFAULT     = 2'd0;
    localparam int          DATA_LAT_DEFAULT = 4;
    localparam logic [19:0] WD_MAX_DEFAULT   = 20'd800000;

    // Watchdog step: counts up and parks at the limit.
    function automatic logic [19:0] wd_step(input logic [19:0] cnt, input logic [19:0] lim);
        if (cnt >= lim) begin
            wd_step = lim;
        end else begin
            wd_step = cnt + 20'd1;
        end
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
        if (cnt == 16'hFFFF) begin
            sat_inc16 = cnt;
        end else begin
            sat_inc16 = cnt + 16'd1;
        end
    endfunction

endpackage

// File: rtl/fetch_tracker.sv
// Tracks the single in-flight video fetch: latches the issue, times the read
// strobe, captures the returned word and routes the valid pulse to its requester.
module fetch_tracker
    import video_pkg::*;
#(
    parameter int DATA_LAT = DATA_LAT_DEFAULT
) (
    input  logic        clk_32,
    input  logic        reset_n,
    input  logic        issue,
    input  logic [22:0] issue_addr,
    input  logic        issue_owner,
    input  logic [63:0] mem_data,
    output logic        mem_read,
    output logic [22:0] mem_addr,
    output logic [63:0] rdata,
    output logic        sh_valid,
    output logic        vk_valid,
    output logic        busy
);

    localparam logic [3:0] LAT_LOAD = 4'(DATA_LAT - 1);

    logic [3:0] lat_cnt_r;
    logic       dest_r;
    logic       last_cycle_s;

    // The strobe itself is the busy indication: it drops on the same edge the
    // data is captured, so a slot in the valid cycle can issue again.
    assign busy         = mem_read;
    assign last_cycle_s = mem_read && (lat_cnt_r == 4'd0);

    // Issue latch and read-strobe duration counter
    always_ff @(posedge clk_32 or negedge reset_n) begin
        if (!reset_n) begin
            mem_read  <= 1'b0;
            mem_addr  <= 23'd0;
            lat_cnt_r <= 4'd0;
            dest_r    <= OWN_SH;
        end else if (issue && !mem_read) begin
            mem_read  <= 1'b1;
            mem_addr  <= issue_addr;
            lat_cnt_r <= LAT_LOAD;
            dest_r    <= issue_owner;
        end else if (last_cycle_s) begin
            mem_read  <= 1'b0;
        end else if (mem_read) begin
            lat_cnt_r <= lat_cnt_r - 4'd1;
        end else begin
            lat_cnt_r <= lat_cnt_r;
        end
    end

    // Data capture on the final strobe cycle and one-cycle valid routing
    always_ff @(posedge clk_32 or negedge reset_n) begin
        if (!reset_n) begin
            rdata    <= 64'd0;
            sh_valid <= 1'b0;
            vk_valid <= 1'b0;
        end else if (last_cycle_s) begin
            rdata    <= mem_data;
            sh_valid <= (dest_r == OWN_SH);
            vk_valid <= (dest_r == OWN_VK);
        end else begin
            sh_valid <= 1'b0;
            vk_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/video_fetch_arbiter.sv
// Shares the 64-bit video read port between the ST shifter and the Viking card,
// switching owner only when idle and at a frame boundary. Optional: VIDEO_ARB_STATS_EN.
module video_fetch_arbiter
    import video_pkg::*;
#(
    parameter logic [1:0]  SLOT     = SLOT_DEFAULT,
    parameter int          DATA_LAT = DATA_LAT_DEFAULT,
    parameter logic [19:0] WD_MAX   = WD_MAX_DEFAULT
) (
    input  logic        clk_32,
    input  logic        reset_n,
    input  logic        clk_8_en,
    input  logic [1:0]  bus_cycle,
    input  logic        viking_enable,
    input  logic        sh_read,
    input  logic [22:0] sh_vaddr,
    input  logic        sh_vs,
    input  logic        vk_read,
    input  logic [22:0] vk_vaddr,
    input  logic        vk_vs,
    output logic        mem_read,
    output logic [22:0] mem_addr,
    input  logic [63:0] mem_data,
    output logic [63:0] rdata,
    output logic        sh_valid,
    output logic        vk_valid,
    output logic        owner,
    output logic        switching
`ifdef VIDEO_ARB_STATS_EN
    ,
    output logic [15:0] skip_cnt
`endif
);

    arb_state_e  state_r;
    arb_state_e  state_nxt_s;
    logic [19:0] wd_r;
    logic        wd_done_s;
    logic        slot_s;
    logic        busy_s;
    logic        issue_s;
    logic [22:0] issue_addr_s;
    logic        issue_owner_s;
    logic        own_nxt_s;
    logic        drain_nxt_s;

    assign slot_s    = clk_8_en && (bus_cycle == SLOT);
    // The current drain cycle is the one that brings the count up to the limit.
    assign wd_done_s = (wd_step(wd_r, WD_MAX) >= WD_MAX);

    assign own_nxt_s   = (state_nxt_s == S_VK) || (state_nxt_s == S_DRAIN_SH);
    assign drain_nxt_s = (state_nxt_s == S_DRAIN_VK) || (state_nxt_s == S_DRAIN_SH);

    // FSM state register
    always_ff @(posedge clk_32 or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_SH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and fetch-issue decode; a level check on viking_enable in the
    // owned states is the rising/falling edge, since the drain exit guarantees
    // the opposite level on arrival.
    always_comb begin
        state_nxt_s   = state_r;
        issue_s       = 1'b0;
        issue_addr_s  = sh_vaddr;
        issue_owner_s = OWN_SH;
        case (state_r)
            S_SH: begin
                issue_s = slot_s && sh_read && !busy_s;
                if (viking_enable) begin
                    state_nxt_s = S_DRAIN_VK;
                end else begin
                    state_nxt_s = S_SH;
                end
            end
            S_VK: begin
                issue_s       = slot_s && vk_read && !busy_s;
                issue_addr_s  = vk_vaddr;
                issue_owner_s = OWN_VK;
                if (!viking_enable) begin
                    state_nxt_s = S_DRAIN_SH;
                end else begin
                    state_nxt_s = S_VK;
                end
            end
            S_DRAIN_VK: begin
                if (busy_s) begin
                    state_nxt_s = S_DRAIN_VK;
                end else if (!viking_enable) begin
                    state_nxt_s = S_SH;
                end else if (vk_vs || wd_done_s) begin
                    state_nxt_s = S_VK;
                end else begin
                    state_nxt_s = S_DRAIN_VK;
                end
            end
            S_DRAIN_SH: begin
                if (busy_s) begin
                    state_nxt_s = S_DRAIN_SH;
                end else if (viking_enable) begin
                    state_nxt_s = S_VK;
                end else if (sh_vs || wd_done_s) begin
                    state_nxt_s = S_SH;
                end else begin
                    state_nxt_s = S_DRAIN_SH;
                end
            end
            default: begin
                state_nxt_s = S_SH;
            end
        endcase
    end

    // Drain watchdog: held at zero outside a drain, so each drain starts fresh
    always_ff @(posedge clk_32 or negedge reset_n) begin
        if (!reset_n) begin
            wd_r <= 20'd0;
        end else if ((state_r == S_SH) || (state_r == S_VK)) begin
            wd_r <= 20'd0;
        end else begin
            wd_r <= wd_step(wd_r, WD_MAX);
        end
    end

    // Owner and drain flags, registered from the next state so they track it
    always_ff @(posedge clk_32 or negedge reset_n) begin
        if (!reset_n) begin
            owner     <= OWN_SH;
            switching <= 1'b0;
        end else begin
            owner     <= own_nxt_s;
            switching <= drain_nxt_s;
        end
    end

    fetch_tracker #(
        .DATA_LAT (DATA_LAT)
    ) u_fetch_tracker (
        .clk_32      (clk_32),
        .reset_n     (reset_n),
        .issue       (issue_s),
        .issue_addr  (issue_addr_s),
        .issue_owner (issue_owner_s),
        .mem_data    (mem_data),
        .mem_read    (mem_read),
        .mem_addr    (mem_addr),
        .rdata       (rdata),
        .sh_valid    (sh_valid),
        .vk_valid    (vk_valid),
        .busy        (busy_s)
    );

`ifdef VIDEO_ARB_STATS_EN
    logic owner_read_s;

    assign owner_read_s = (owner == OWN_VK) ? vk_read : sh_read;

    // Owner slots that went unserved; restarts whenever ownership flips
    always_ff @(posedge clk_32 or negedge reset_n) begin
        if (!reset_n) begin
            skip_cnt <= 16'd0;
        end else if (own_nxt_s != owner) begin
            skip_cnt <= 16'd0;
        end else if (slot_s && owner_read_s && !issue_s) begin
            skip_cnt <= sat_inc16(skip_cnt);
        end else begin
            skip_cnt <= skip_cnt;
        end
    end
`endif

endmodule
